// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl -- sequences a 32x32 multiply through a 16x16 three-partial-
// product multiplier cell in one pass (MUL, low 32 bits) or two passes
// (MULXUU/MULXSU/MULXSS, high 32 bits). One operation in flight.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   req_valid/req_ready   request handshake; req_op selects the operation
//   req_src1/req_src2     operands, latched on accept
//   resp_valid/resp_ready response handshake; resp_data holds the result
//   mul_src1/mul_src2     operands driven to the cell
//   mul_en                cell enable (high only while a pass is running)
//   mul_p1/mul_p2/mul_p3  cell partial products lo*lo, lo*hi, hi*lo
//   perf_mul_cnt          completed-operation counter (only when the
//                         MUL_SEQ_PERF_CNT_EN macro is defined)
//
// Parameter MUL_LATENCY (1..4): enabled clock edges from operands to valid
// partial products.
module mul_seq_ctrl #(
  parameter int unsigned MUL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [31:0] mul_src1,
  output logic [31:0] mul_src2,
  output logic        mul_en,
`ifdef MUL_SEQ_PERF_CNT_EN
  output logic [31:0] perf_mul_cnt,
`endif
  input  logic [31:0] mul_p1,
  input  logic [31:0] mul_p2,
  input  logic [31:0] mul_p3
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULXSS = 2'b11;
  localparam logic [2:0] LAST_CNT  = 3'(MUL_LATENCY);

  state_t      state, state_next;
  logic [2:0]  cnt, cnt_next;
  logic [1:0]  op, op_next;
  logic [31:0] a, a_next;
  logic [31:0] b, b_next;
  logic [63:0] acc, acc_next;
  logic [31:0] resp_data_next;
  logic        resp_valid_next;
  logic        req_ready_next;
  logic        mul_en_next;
  logic [31:0] mul_src1_next, mul_src2_next;

  logic [32:0] mid_sum;
  logic [63:0] pass1_acc;
  logic [63:0] corr_a, corr_b;

  // Partial-product combination and signed high-word corrections.
  always_comb begin
    // p2+p3 can carry into bit 32; keep it before shifting into place.
    mid_sum   = {1'b0, mul_p2} + {1'b0, mul_p3};
    pass1_acc = {32'h0000_0000, mul_p1} + {15'h0000, mid_sum, 16'h0000};
    // Treating a signed operand as unsigned overcounts by 2^32 * other operand.
    if (a[31] && op[1]) begin
      corr_a = {b, 32'h0000_0000};
    end else begin
      corr_a = 64'h0;
    end
    if (b[31] && (op == OP_MULXSS)) begin
      corr_b = {a, 32'h0000_0000};
    end else begin
      corr_b = 64'h0;
    end
  end

  // Next-state logic and next values of all registered outputs.
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    op_next         = op;
    a_next          = a;
    b_next          = b;
    acc_next        = acc;
    resp_data_next  = resp_data;
    resp_valid_next = resp_valid;
    case (state)
      IDLE: begin
        if (req_valid) begin
          op_next    = req_op;
          a_next     = req_src1;
          b_next     = req_src2;
          cnt_next   = 3'd0;
          acc_next   = 64'h0;
          state_next = PASS1;
        end else begin
          state_next = IDLE;
        end
      end
      PASS1: begin
        if (cnt == LAST_CNT) begin
          acc_next   = pass1_acc;
          cnt_next   = 3'd0;
          state_next = (op == OP_MUL) ? DONE : PASS2;
        end else begin
          cnt_next = cnt + 3'd1;
        end
      end
      PASS2: begin
        if (cnt == LAST_CNT) begin
          // In this pass the cell's lo*lo product is A_hi*B_hi.
          acc_next   = acc + {mul_p1, 32'h0000_0000} - corr_a - corr_b;
          cnt_next   = 3'd0;
          state_next = DONE;
        end else begin
          cnt_next = cnt + 3'd1;
        end
      end
      DONE: begin
        // First DONE cycle registers the result; it is then held until taken.
        if (!resp_valid) begin
          resp_valid_next = 1'b1;
          resp_data_next  = (op == OP_MUL) ? acc[31:0] : acc[63:32];
        end else if (resp_ready) begin
          resp_valid_next = 1'b0;
          state_next      = IDLE;
        end else begin
          resp_valid_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Cell-facing outputs are registered from the upcoming state.
    req_ready_next = (state_next == IDLE);
    mul_en_next    = (state_next == PASS1) || (state_next == PASS2);
    if (state_next == PASS1) begin
      mul_src1_next = a_next;
      mul_src2_next = b_next;
    end else if (state_next == PASS2) begin
      mul_src1_next = {16'h0000, a_next[31:16]};
      mul_src2_next = {16'h0000, b_next[31:16]};
    end else begin
      mul_src1_next = 32'h0;
      mul_src2_next = 32'h0;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      op         <= 2'b00;
      a          <= 32'h0;
      b          <= 32'h0;
      acc        <= 64'h0;
      resp_data  <= 32'h0;
      resp_valid <= 1'b0;
      req_ready  <= 1'b1;
      mul_en     <= 1'b0;
      mul_src1   <= 32'h0;
      mul_src2   <= 32'h0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      op         <= op_next;
      a          <= a_next;
      b          <= b_next;
      acc        <= acc_next;
      resp_data  <= resp_data_next;
      resp_valid <= resp_valid_next;
      req_ready  <= req_ready_next;
      mul_en     <= mul_en_next;
      mul_src1   <= mul_src1_next;
      mul_src2   <= mul_src2_next;
    end
  end

`ifdef MUL_SEQ_PERF_CNT_EN
  // Completed-operation counter, wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_mul_cnt <= 32'h0;
    end else if (resp_valid && resp_ready) begin
      perf_mul_cnt <= perf_mul_cnt + 32'd1;
    end else begin
      perf_mul_cnt <= perf_mul_cnt;
    end
  end
`endif

endmodule
